// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter and sequencer for the single-port data memory.
// One transaction at a time: IDLE (grant) -> ACCESS (memory cycle) -> RESP (held).
module dmem_arbiter #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_valid,
    input  logic                  req0_we,
    input  logic [DM_ADDRESS-1:0] req0_addr,
    input  logic [DATA_W-1:0]     req0_wdata,
    output logic                  req0_ready,
    output logic                  rsp0_valid,
    output logic [DATA_W-1:0]     rsp0_rdata,
    input  logic                  rsp0_ready,
    input  logic                  req1_valid,
    input  logic                  req1_we,
    input  logic [DM_ADDRESS-1:0] req1_addr,
    input  logic [DATA_W-1:0]     req1_wdata,
    output logic                  req1_ready,
    output logic                  rsp1_valid,
    output logic [DATA_W-1:0]     rsp1_rdata,
    input  logic                  rsp1_ready,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [DM_ADDRESS-1:0] mem_a,
    output logic [DATA_W-1:0]     mem_wd,
    input  logic [DATA_W-1:0]     mem_rd
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic                  ptr_q, ptr_d;
    logic [DM_ADDRESS-1:0] addr_q, addr_d;
    logic                  we_q, we_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic                  id_q, id_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;

    logic gnt_vld;
    logic gnt_id;

    // Pick the requester: a lone valid wins, a tie goes to the pointer.
    always_comb begin
        gnt_vld = req0_valid | req1_valid;
        gnt_id  = req1_valid & (~req0_valid | ptr_q);
    end

    // Next-state, capture and output decode for the transaction sequencer.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        id_d       = id_q;
        rdata_d    = rdata_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        rsp0_rdata = '0;
        rsp1_rdata = '0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_a      = '0;
        mem_wd     = '0;

        unique case (state_q)
            IDLE: begin
                req0_ready = gnt_vld & ~gnt_id;
                req1_ready = gnt_vld & gnt_id;
                if (gnt_vld) begin
                    state_d = ACCESS;
                    id_d    = gnt_id;
                    addr_d  = gnt_id ? req1_addr  : req0_addr;
                    we_d    = gnt_id ? req1_we    : req0_we;
                    wdata_d = gnt_id ? req1_wdata : req0_wdata;
                end
            end
            ACCESS: begin
                mem_a     = addr_q;
                mem_wd    = wdata_q;
                mem_write = we_q;
                mem_read  = ~we_q;
                rdata_d   = we_q ? '0 : mem_rd;
                ptr_d     = ~id_q;
                state_d   = RESP;
            end
            RESP: begin
                rsp0_valid = ~id_q;
                rsp1_valid = id_q;
                rsp0_rdata = id_q ? '0 : rdata_q;
                rsp1_rdata = id_q ? rdata_q : '0;
                if (id_q ? rsp1_ready : rsp0_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A memory cycle overlapping reset must not touch the array.
        if (reset) begin
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            req0_ready = 1'b0;
            req1_ready = 1'b0;
        end
    end

    // State and captured-transaction registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            id_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            id_q    <= id_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-port arbiter and sequencer in front of the single-port data memory (combinational read, posedge write). It shares the memory between requester 0 (core load/store path) and requester 1 (debug/DMA loader). Arbitration is round-robin with valid/ready request and response handshakes. It owns the memory's MemRead/MemWrite/address/write-data inputs and registers the read data into a held response.

Parameters:
DM_ADDRESS, 9, word-address width of data memory
DATA_W, 32, data word width

Ports:
clk  input  1  clock, all state on posedge
reset  input  1  synchronous, active-high reset
req0_valid  input  1  requester 0 has a request
req0_we  input  1  1=write, 0=read
req0_addr  input  DM_ADDRESS  word address
req0_wdata  input  DATA_W  write data
req0_ready  output  1  request 0 accepted this cycle
rsp0_valid  output  1  response for requester 0 available
rsp0_rdata  output  DATA_W  read data (0 for write acks)
rsp0_ready  input  1  requester 0 consumes response
req1_valid, req1_we, req1_addr, req1_wdata, req1_ready, rsp1_valid, rsp1_rdata, rsp1_ready: same as port 0, for requester 1
mem_read  output  1  to memory MemRead
mem_write  output  1  to memory MemWrite
mem_a  output  DM_ADDRESS  to memory address
mem_wd  output  DATA_W  to memory write data
mem_rd  input  DATA_W  from memory read data

Behaviour:
- One clock; reset is synchronous and active-high. Ports are named clk and reset.
- Reset: state=IDLE, priority pointer=0 (req0 favoured), all outputs 0, captured addr/we/wdata/id/rdata registers cleared.
- FSM states:
  - IDLE to ACCESS on any req valid.
  - ACCESS to RESP unconditionally.
  - RESP to IDLE when rsp_ready of the owning id is 1.
- IDLE:
  - reqN_ready = (state==IDLE) && grant==N, combinational.
  - Grant goes to the only valid requester. If both are valid, grant goes to the pointer's requester.
  - On the accept edge, latch addr/we/wdata/id.
- ACCESS (exactly 1 cycle):
  - mem_a=latched addr, mem_wd=latched wdata, mem_write=we, mem_read=!we.
  - Write commits at the closing edge.
  - The same edge captures rdata=mem_rd for reads, or rdata=0 for writes.
  - The same edge sets pointer = ~id.
- Outside ACCESS: mem_read=mem_write=0, mem_a=0, mem_wd=0.
- While reset=1, mem_read and mem_write are forced to 0 regardless of state. A write whose ACCESS cycle coincides with reset is dropped.
- RESP:
  - rspN_valid=1 only for N==id. rdata is held stable on both rspN_rdata (other port's rdata=0).
  - Remaining in RESP while rsp_ready=0 is unbounded (backpressure).
  - No new request is accepted until the FSM returns to IDLE.
- Latency and throughput: accepted at edge T, rsp_valid high from T+2 (the cycle after the ACCESS cycle). Minimum 3 cycles per transaction.
- Requester rules:
  - Fields must stay stable while valid=1 and ready=0.
  - Valid may be withdrawn before ready without effect.
  - A response is consumed only when valid=1 and ready=1 in the same cycle.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1. A lone requester is granted every transaction.
- rsp_ready asserted outside RESP is ignored.
- Address is a word index; no byte enables, no address range checks (all 2**DM_ADDRESS words are legal, wrap is the requester's concern).
- Reset mid-RESP or mid-ACCESS: returns to IDLE next edge, response discarded, pointer back to 0.

Test Plan:
- Write then read: req0 write addr=5 data=0xDEADBEEF, ack at T+2 with rdata=0. Then req0 read addr=5 gives rsp0_rdata=0xDEADBEEF at T+2, and mem_read high only in the ACCESS cycle.
- Contention: both valid from reset, req0 read addr 1, req1 read addr 2, rsp_ready tied 1. Grant order is 0,1,0,1; each response comes from the correct address, and the other port's rsp_valid stays 0.
- Backpressure: req1 read addr 7 (preloaded 0x1234), rsp1_ready held low 5 cycles. rsp1_valid stays high with 0x1234 stable, req0_ready stays 0 throughout, and the FSM returns to IDLE the cycle after rsp1_ready=1.
- Lone requester: only req1 valid for 4 back-to-back reads. All are granted to req1, each at 3-cycle spacing.
- Reset during write ACCESS: req0 write addr 3 data 0xAAAA with reset asserted in the ACCESS cycle. mem_write is 0 that cycle, and a later read of addr 3 returns its old value. Outputs are 0 after reset.
- Valid withdrawal: req1_valid pulses one cycle while the FSM is in RESP for req0. No grant to req1, and no memory access is generated.
